// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the fetch PC, issues one request at a time on the
// instruction-memory port, and hands each returned word plus its PC to the core.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_upd_valid,
  input  logic [31:0] pc_upd,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  output logic [31:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_NEXT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_fault_q, out_fault_d;
  logic        misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_fault_d = out_fault_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // A misaligned PC never reaches memory; it is reported as a faulting NOP.
        if (misaligned) begin
          state_d     = S_HOLD;
          out_inst_d  = NOP_INST;
          out_pc_d    = pc_q;
          out_fault_d = 1'b1;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d     = S_HOLD;
          out_inst_d  = imem_rsp_err ? NOP_INST : imem_rsp_data;
          out_pc_d    = pc_q;
          out_fault_d = imem_rsp_err;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (pc_upd_valid) begin
            pc_d    = pc_upd;
            state_d = S_REQ;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (pc_upd_valid) begin
          pc_d    = pc_upd;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      out_inst_q  <= 32'h0;
      out_pc_q    <= 32'h0;
      out_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_fault_q <= out_fault_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ) && !misaligned;
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == S_HOLD);
  assign out_inst       = out_inst_q;
  assign out_pc         = out_pc_q;
  assign out_fault      = out_fault_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch: each task drives one scenario and
// compares outputs against hand-computed values one time unit after the clock edge.
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        pc_upd_valid;
  logic [31:0] pc_upd;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic [31:0] pc;

  int total = 0;
  int bad   = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_upd_valid   (pc_upd_valid),
    .pc_upd         (pc_upd),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .pc             (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_upd_valid   = 1'b0;
    pc_upd         = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    out_ready      = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    total++; if (pc !== 32'h8000_0000) begin bad++; $display("[TB] FAIL reset_pc got=%h want=%h", pc, 32'h8000_0000); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_valid got=%b want=0", imem_req_valid); end
    total++; if (out_inst !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_inst got=%h want=0", out_inst); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_pc got=%h want=0", out_pc); end
    total++; if (out_fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_fault got=%b want=0", out_fault); end
    rst_n = 1'b1;
    step();
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("[TB] FAIL first_req_valid got=%b want=1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h8000_0000) begin bad++; $display("[TB] FAIL first_req_addr got=%h want=%h", imem_req_addr, 32'h8000_0000); end
  endtask

  task automatic test_basic_fetch();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL wait_req_valid got=%b want=0", imem_req_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    step();
    imem_rsp_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_out_valid got=%b want=1", out_valid); end
    total++; if (out_inst !== 32'h0010_0093) begin bad++; $display("[TB] FAIL basic_out_inst got=%h want=%h", out_inst, 32'h0010_0093); end
    total++; if (out_pc !== 32'h8000_0000) begin bad++; $display("[TB] FAIL basic_out_pc got=%h want=%h", out_pc, 32'h8000_0000); end
    total++; if (out_fault !== 1'b0) begin bad++; $display("[TB] FAIL basic_out_fault got=%b want=0", out_fault); end
  endtask

  task automatic test_zero_bubble();
    out_ready    = 1'b1;
    pc_upd_valid = 1'b1;
    pc_upd       = 32'h8000_0004;
    step();
    out_ready    = 1'b0;
    pc_upd_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("[TB] FAIL zb_req_valid got=%b want=1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h8000_0004) begin bad++; $display("[TB] FAIL zb_req_addr got=%h want=%h", imem_req_addr, 32'h8000_0004); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL zb_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_stall();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
        bad++; $display("[TB] FAIL stall_req_hold[%0d] got valid=%b addr=%h want valid=1 addr=%h", i, imem_req_valid, imem_req_addr, 32'h8000_0000);
      end
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    // Updates offered while waiting on memory must be ignored.
    pc_upd_valid = 1'b1;
    pc_upd       = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc !== 32'h8000_0000) begin
        bad++; $display("[TB] FAIL stall_wait[%0d] got out_valid=%b req_valid=%b pc=%h want 0 0 %h", i, out_valid, imem_req_valid, pc, 32'h8000_0000);
      end
    end
    pc_upd_valid   = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0020_0113;
    step();
    imem_rsp_data  = 32'h0030_0193;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_inst !== 32'h0020_0113) begin
        bad++; $display("[TB] FAIL stall_hold[%0d] got out_valid=%b inst=%h want 1 %h", i, out_valid, out_inst, 32'h0020_0113);
      end
    end
    imem_rsp_valid = 1'b0;
    out_ready      = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc !== 32'h8000_0000) begin
        bad++; $display("[TB] FAIL next_wait[%0d] got out_valid=%b req_valid=%b pc=%h want 0 0 %h", i, out_valid, imem_req_valid, pc, 32'h8000_0000);
      end
      step();
    end
  endtask

  task automatic test_misaligned();
    pc_upd_valid = 1'b1;
    pc_upd       = 32'h8000_0002;
    imem_req_ready = 1'b1;
    step();
    pc_upd_valid = 1'b0;
    total++; if (pc !== 32'h8000_0002) begin bad++; $display("[TB] FAIL mis_pc got=%h want=%h", pc, 32'h8000_0002); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL mis_req_valid got=%b want=0", imem_req_valid); end
    step();
    imem_req_ready = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mis_out_valid got=%b want=1", out_valid); end
    total++; if (out_fault !== 1'b1) begin bad++; $display("[TB] FAIL mis_out_fault got=%b want=1", out_fault); end
    total++; if (out_inst !== 32'h0000_0013) begin bad++; $display("[TB] FAIL mis_out_inst got=%h want=%h", out_inst, 32'h0000_0013); end
    total++; if (out_pc !== 32'h8000_0002) begin bad++; $display("[TB] FAIL mis_out_pc got=%h want=%h", out_pc, 32'h8000_0002); end
  endtask

  task automatic test_rsp_err();
    out_ready    = 1'b1;
    pc_upd_valid = 1'b1;
    pc_upd       = 32'h8000_0008;
    step();
    out_ready      = 1'b0;
    pc_upd_valid   = 1'b0;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = 32'h1111_1111;
    total++; if (out_inst !== 32'h0000_0013) begin bad++; $display("[TB] FAIL err_out_inst got=%h want=%h", out_inst, 32'h0000_0013); end
    total++; if (out_fault !== 1'b1) begin bad++; $display("[TB] FAIL err_out_fault got=%b want=1", out_fault); end
    total++; if (out_pc !== 32'h8000_0008) begin bad++; $display("[TB] FAIL err_out_pc got=%h want=%h", out_pc, 32'h8000_0008); end
    step();
    imem_rsp_valid = 1'b0;
    total++; if (out_inst !== 32'h0000_0013 || out_fault !== 1'b1 || out_valid !== 1'b1) begin
      bad++; $display("[TB] FAIL spurious_rsp got inst=%h fault=%b valid=%b want %h 1 1", out_inst, out_fault, out_valid, 32'h0000_0013);
    end
  endtask

  task automatic test_reset_mid();
    out_ready    = 1'b1;
    pc_upd_valid = 1'b1;
    pc_upd       = 32'h8000_000C;
    step();
    out_ready      = 1'b0;
    pc_upd_valid   = 1'b0;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    total++; if (pc !== 32'h8000_0000 || out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_state got pc=%h out_valid=%b req_valid=%b want %h 0 0", pc, out_valid, imem_req_valid, 32'h8000_0000);
    end
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_BABE;
    step();
    step();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_restart got req_valid=%b addr=%h out_valid=%b want 1 %h 0", imem_req_valid, imem_req_addr, out_valid, 32'h8000_0000);
    end
    total++; if (out_inst !== 32'h0) begin bad++; $display("[TB] FAIL midrst_stale got=%h want=0", out_inst); end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0040_0213;
    step();
    imem_rsp_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_inst !== 32'h0040_0213 || out_pc !== 32'h8000_0000) begin
      bad++; $display("[TB] FAIL midrst_refetch got valid=%b inst=%h pc=%h want 1 %h %h", out_valid, out_inst, out_pc, 32'h0040_0213, 32'h8000_0000);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_zero_bubble();
    test_stall();
    test_misaligned();
    test_rsp_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
